// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the architectural PC and fetches one instruction word at a time.
// It holds the word until the consumer retires it, and halts on a misaligned next PC.
//
// state | meaning
// ------+---------------------------------------------------------------
// FETCH | request driven at PC_old, waiting for grant
// WAIT  | request granted, waiting for read data
// HOLD  | instruction valid and stable, waiting for instr_ready
// HALT  | misaligned next PC seen, frozen until reset
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          COUNT_W  = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic [31:0]        PC_old,
  input  logic [31:0]        PC_next,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        instruction,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               fault,
  output logic [COUNT_W-1:0] instr_count
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [31:0]        r_pc;
  logic [31:0]        w_pc_nxt;
  logic [31:0]        r_instr;
  logic [31:0]        w_instr_nxt;
  logic               r_valid;
  logic               w_valid_nxt;
  logic               r_fault;
  logic               w_fault_nxt;
  logic [COUNT_W-1:0] r_count;
  logic [COUNT_W-1:0] w_count_nxt;
  logic               w_aligned;

  assign w_aligned = (PC_next[1:0] == 2'b00);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_instr_nxt = r_instr;
    w_valid_nxt = r_valid;
    w_fault_nxt = r_fault;
    w_count_nxt = r_count;
    case (r_state)
      FETCH: begin
        if (imem_gnt) begin
          if (imem_rvalid) begin
            w_instr_nxt = imem_rdata;
            w_valid_nxt = 1'b1;
            w_state_nxt = HOLD;
          end else begin
            w_state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          w_instr_nxt = imem_rdata;
          w_valid_nxt = 1'b1;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (instr_ready) begin
          w_valid_nxt = 1'b0;
          if (w_aligned) begin
            w_pc_nxt    = PC_next;
            w_count_nxt = r_count + COUNT_W'(1);
            w_state_nxt = FETCH;
          end else begin
            w_fault_nxt = 1'b1;
            w_state_nxt = HALT;
          end
        end
      end
      HALT: begin
        w_state_nxt = HALT;
      end
      default: begin
        w_state_nxt = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc    <= RESET_PC;
      r_instr <= 32'h0;
      r_valid <= 1'b0;
      r_fault <= 1'b0;
      r_count <= '0;
    end else begin
      r_pc    <= w_pc_nxt;
      r_instr <= w_instr_nxt;
      r_valid <= w_valid_nxt;
      r_fault <= w_fault_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Gating with reset_n drops the request asynchronously while reset is held.
  assign imem_req    = (r_state == FETCH) && reset_n;
  assign imem_addr   = r_pc;
  assign PC_old      = r_pc;
  assign instruction = r_instr;
  assign instr_valid = r_valid;
  assign fault       = r_fault;
  assign instr_count = r_count;

endmodule
